// File: rtl/bit_extract_lookup.sv
// Bit-extraction lookup: captures packet header segments, runs per-bit extract instructions, emits key+mask.
// Optional BIT_EXTRACT_DROPCNT_EN adds a saturating o_drop_cnt of completions dropped while busy.
module bit_extract_lookup #(
  parameter int C_AXIS_DATA_WIDTH   = 256,
  parameter int SEG_ADDR            = 3,
  parameter int HDR_SEGS            = 4,
  parameter int CFG_ORDER_NUM       = 128,
  parameter int CFG_SINGE_ORDER_WID = 16,
  parameter int LANES               = 32
) (
  input  logic                                          axis_clk,
  input  logic                                          aresetn,
  input  logic [C_AXIS_DATA_WIDTH-1:0]                  i_dp_segs_tdata,
  input  logic                                          i_dp_segs_valid,
  input  logic                                          i_dp_segs_wea,
  input  logic [SEG_ADDR-1:0]                           i_dp_segs_addra,
  input  logic [CFG_ORDER_NUM*CFG_SINGE_ORDER_WID-1:0]  i_cfg_bit_info,
  input  logic                                          i_cfg_bit_updata,
  output logic [CFG_ORDER_NUM-1:0]                      o_dp_key,
  output logic [CFG_ORDER_NUM-1:0]                      o_dp_key_mask,
  output logic                                          o_dp_key_valid,
  input  logic                                          i_dp_key_ready,
  output logic [C_AXIS_DATA_WIDTH-1:0]                  o_dp_segs_tdata,
  output logic                                          o_dp_segs_valid,
  output logic                                          o_dp_segs_wea,
  output logic [SEG_ADDR-1:0]                           o_dp_segs_addra,
  output logic                                          o_cfg_busy
`ifdef BIT_EXTRACT_DROPCNT_EN
  ,
  output logic [31:0]                                   o_drop_cnt
`endif
);

  localparam int W         = C_AXIS_DATA_WIDTH;
  localparam int OW        = CFG_SINGE_ORDER_WID;
  localparam int HDR_BITS  = HDR_SEGS * W;
  localparam int HDR_BYTES = HDR_BITS / 8;
  localparam int GROUPS    = CFG_ORDER_NUM / LANES;
  localparam int GW        = $clog2(GROUPS + 1);
  localparam int KW        = $clog2(CFG_ORDER_NUM);
  localparam int HB        = $clog2(HDR_BITS);

  typedef enum logic [1:0] {IDLE, EXTRACT, OUT} state_t;

  state_t                state;
  logic [GW-1:0]         grp;
  logic [W-1:0]          hdr_slot   [HDR_SEGS];
  logic [HDR_BITS-1:0]   hdr_lin;
  logic [OW-1:0]         shadow_tbl [CFG_ORDER_NUM];
  logic [OW-1:0]         active_tbl [CFG_ORDER_NUM];
  logic                  cfg_busy;
  logic [LANES-1:0]      lane_key;
  logic [LANES-1:0]      lane_mask;
  logic [LANES-1:0]      pipe_key;
  logic [LANES-1:0]      pipe_mask;
  logic [GW-1:0]         pipe_grp;
  logic                  pipe_vld;
  logic                  wr_evt;
  logic                  complete_evt;

  assign o_dp_segs_tdata = i_dp_segs_tdata;
  assign o_dp_segs_valid = i_dp_segs_valid;
  assign o_dp_segs_wea   = i_dp_segs_wea;
  assign o_dp_segs_addra = i_dp_segs_addra;
  assign o_cfg_busy      = cfg_busy;

  assign wr_evt       = i_dp_segs_valid & i_dp_segs_wea;
  assign complete_evt = wr_evt && (32'(i_dp_segs_addra) == HDR_SEGS - 1);

  // Linear header bit address 8*byte+idx maps to network-order bit (MSB of byte 0 first).
  for (genvar s = 0; s < HDR_SEGS; s++) begin : g_seg
    for (genvar q = 0; q < W; q++) begin : g_bit
      assign hdr_lin[s*W + q] = hdr_slot[s][W-1-q];
    end
  end

  function automatic logic [1:0] eval_instr(input logic [OW-1:0] ins, input logic [HDR_BITS-1:0] hdr);
    logic [OW-5:0] off;
    logic [2:0]    idx;
    logic [HB-1:0] pos;
    off = ins[OW-2:3];
    idx = ins[2:0];
    pos = HB'({off, idx});
    eval_instr = 2'b00;
    if (ins[OW-1] && (32'(off) < HDR_BYTES))
      eval_instr = {hdr[pos], 1'b1};
  endfunction

  always_comb begin
    lane_key  = '0;
    lane_mask = '0;
    for (int l = 0; l < LANES; l++)
      {lane_key[l], lane_mask[l]} = eval_instr(active_tbl[KW'(int'(grp) * LANES + l)], hdr_lin);
  end

  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int s = 0; s < HDR_SEGS; s++) hdr_slot[s] <= '0;
    end else if (wr_evt && state != EXTRACT) begin
      for (int s = 0; s < HDR_SEGS; s++)
        if (32'(i_dp_segs_addra) == s) hdr_slot[s] <= i_dp_segs_tdata;
    end
  end

  // Shadow commits only in IDLE on a cycle without a completion, so one key never sees two tables.
  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int k = 0; k < CFG_ORDER_NUM; k++) begin
        shadow_tbl[k] <= '0;
        active_tbl[k] <= '0;
      end
      cfg_busy <= 1'b0;
    end else if (i_cfg_bit_updata) begin
      for (int k = 0; k < CFG_ORDER_NUM; k++) shadow_tbl[k] <= i_cfg_bit_info[k*OW +: OW];
      cfg_busy <= 1'b1;
    end else if (cfg_busy && state == IDLE && !complete_evt) begin
      for (int k = 0; k < CFG_ORDER_NUM; k++) active_tbl[k] <= shadow_tbl[k];
      cfg_busy <= 1'b0;
    end
  end

  // Lane results are registered once before landing in the key, hence one extra EXTRACT cycle.
  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      state          <= IDLE;
      grp            <= '0;
      pipe_key       <= '0;
      pipe_mask      <= '0;
      pipe_grp       <= '0;
      pipe_vld       <= 1'b0;
      o_dp_key       <= '0;
      o_dp_key_mask  <= '0;
      o_dp_key_valid <= 1'b0;
    end else begin
      pipe_vld <= 1'b0;
      if (pipe_vld) begin
        for (int g = 0; g < GROUPS; g++) begin
          if (pipe_grp == GW'(g)) begin
            o_dp_key[g*LANES +: LANES]      <= pipe_key;
            o_dp_key_mask[g*LANES +: LANES] <= pipe_mask;
          end
        end
      end
      case (state)
        IDLE: begin
          if (complete_evt) begin
            state <= EXTRACT;
            grp   <= '0;
          end
        end
        EXTRACT: begin
          if (grp == GW'(GROUPS)) begin
            state          <= OUT;
            o_dp_key_valid <= 1'b1;
          end else begin
            pipe_key  <= lane_key;
            pipe_mask <= lane_mask;
            pipe_grp  <= grp;
            pipe_vld  <= 1'b1;
            grp       <= grp + 1'b1;
          end
        end
        OUT: begin
          if (i_dp_key_ready) begin
            state          <= IDLE;
            o_dp_key_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BIT_EXTRACT_DROPCNT_EN
  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn)
      o_drop_cnt <= '0;
    else if (complete_evt && state != IDLE && o_drop_cnt != 32'hFFFF_FFFF)
      o_drop_cnt <= o_drop_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_bit_extract_lookup.sv
// Directed self-checking bench for bit_extract_lookup (default parameters).
module tb_bit_extract_lookup;

  localparam int W = 256, SA = 3, HS = 4, N = 128, OW = 16, LANES = 32;

  localparam logic [N-1:0] KEY_A_H  = 128'h8000_0000_0000_0001_0000_0000_0000_0004;
  localparam logic [N-1:0] MASK_A   = 128'h8000_0000_0000_0001_0000_0000_0000_000C;
  localparam logic [N-1:0] KEY_A_2  = 128'h0000_0000_0000_0001_0000_0000_0000_0000;
  localparam logic [N-1:0] BIT0     = 128'h1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [W-1:0]      tdata = '0;
  logic              seg_valid = 1'b0, seg_wea = 1'b0;
  logic [SA-1:0]     seg_addra = '0;
  logic [N*OW-1:0]   cfg_info = '0;
  logic              cfg_upd = 1'b0;
  logic [N-1:0]      key, key_mask;
  logic              key_valid;
  logic              key_ready = 1'b0;
  logic [W-1:0]      o_tdata;
  logic              o_valid, o_wea;
  logic [SA-1:0]     o_addra;
  logic              busy;
`ifdef BIT_EXTRACT_DROPCNT_EN
  logic [31:0]       drop_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [HS*W-1:0] hdr_first, hdr_h, hdr_2;
  logic [N*OW-1:0] tbl_first, tbl_a;

  always #5 clk = ~clk;

  bit_extract_lookup #(
    .C_AXIS_DATA_WIDTH(W), .SEG_ADDR(SA), .HDR_SEGS(HS),
    .CFG_ORDER_NUM(N), .CFG_SINGE_ORDER_WID(OW), .LANES(LANES)
  ) dut (
    .axis_clk(clk), .aresetn(rst_n),
    .i_dp_segs_tdata(tdata), .i_dp_segs_valid(seg_valid), .i_dp_segs_wea(seg_wea),
    .i_dp_segs_addra(seg_addra), .i_cfg_bit_info(cfg_info), .i_cfg_bit_updata(cfg_upd),
    .o_dp_key(key), .o_dp_key_mask(key_mask), .o_dp_key_valid(key_valid),
    .i_dp_key_ready(key_ready),
    .o_dp_segs_tdata(o_tdata), .o_dp_segs_valid(o_valid), .o_dp_segs_wea(o_wea),
    .o_dp_segs_addra(o_addra), .o_cfg_busy(busy)
`ifdef BIT_EXTRACT_DROPCNT_EN
    , .o_drop_cnt(drop_cnt)
`endif
  );

  function automatic logic [15:0] mk(input logic en, input int off, input int idx);
    return {en, 12'(off), 3'(idx)};
  endfunction

  task automatic drive_seg(input logic [SA-1:0] a, input logic [W-1:0] d);
    seg_valid = 1'b1; seg_wea = 1'b1; seg_addra = a; tdata = d;
    @(negedge clk);
    seg_valid = 1'b0; seg_wea = 1'b0;
  endtask

  // Returns at the negedge right after the completing (last-segment) edge.
  task automatic send_header(input logic [HS*W-1:0] h);
    for (int s = 0; s < HS; s++) drive_seg(SA'(s), h[HS*W-1-W*s -: W]);
  endtask

  task automatic load_table(input logic [N*OW-1:0] t);
    cfg_info = t; cfg_upd = 1'b1;
    @(negedge clk);
    cfg_upd = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (key_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (key_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL %s: key_valid=%b after %0d cycles, expected 1", name, key_valid, n);
    end
  endtask

  task automatic accept();
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    vectors++;
    if (key_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_ctl: valid=%b busy=%b, expected 0 0", key_valid, busy);
    end
    vectors++;
    if (key !== '0 || key_mask !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_key: key=%h mask=%h, expected 0 0", key, key_mask);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_passthrough();
    seg_valid = 1'b1; seg_wea = 1'b0; seg_addra = 3'd5; tdata = {8{32'hA5C3_0F17}};
    #1;
    vectors++;
    if (o_tdata !== {8{32'hA5C3_0F17}} || o_valid !== 1'b1 || o_wea !== 1'b0 || o_addra !== 3'd5) begin
      miscompares++;
      $display("[TB] FAIL passthrough: v=%b w=%b a=%0d, expected 1 0 5", o_valid, o_wea, o_addra);
    end
    @(negedge clk);
    seg_valid = 1'b0; tdata = '0; seg_addra = '0;
  endtask

  task automatic test_first_bit();
    load_table(tbl_first);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL busy_set: busy=%b, expected 1", busy);
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL busy_clear: busy=%b, expected 0", busy);
    end
    send_header(hdr_first);
    repeat (4) @(negedge clk);
    vectors++;
    if (key_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL latency_early: valid=%b at T+4, expected 0", key_valid);
    end
    @(negedge clk);
    vectors++;
    if (key_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL latency: valid=%b at T+5, expected 1", key_valid);
    end
    vectors++;
    if (key !== BIT0 || key_mask !== BIT0) begin
      miscompares++;
      $display("[TB] FAIL first_bit: key=%h mask=%h, expected %h %h", key, key_mask, BIT0, BIT0);
    end
    accept();
    vectors++;
    if (key_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL first_accept: valid=%b, expected 0", key_valid);
    end
  endtask

  task automatic test_boundary();
    load_table(tbl_a);
    @(negedge clk);
    send_header(hdr_h);
    wait_valid("boundary_valid");
    vectors++;
    if (key !== KEY_A_H || key_mask !== MASK_A) begin
      miscompares++;
      $display("[TB] FAIL boundary: key=%h mask=%h, expected %h %h", key, key_mask, KEY_A_H, MASK_A);
    end
    accept();
  endtask

  task automatic test_back_to_back();
    send_header(hdr_h);
    wait_valid("hold_valid");
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      vectors++;
      if (key_valid !== 1'b1 || key !== KEY_A_H || key_mask !== MASK_A) begin
        miscompares++;
        $display("[TB] FAIL hold_c%0d: valid=%b key=%h, expected 1 %h", c, key_valid, key, KEY_A_H);
      end
    end
    accept();
    vectors++;
    if (key_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL hold_release: valid=%b, expected 0", key_valid);
    end
    send_header(hdr_2);
    wait_valid("second_valid");
    vectors++;
    if (key !== KEY_A_2 || key_mask !== MASK_A) begin
      miscompares++;
      $display("[TB] FAIL second_key: key=%h mask=%h, expected %h %h", key, key_mask, KEY_A_2, MASK_A);
    end
    accept();
  endtask

  task automatic test_drop();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    load_table(tbl_a);
    @(negedge clk);
    send_header(hdr_h);
    @(negedge clk);
    drive_seg(SA'(HS - 1), '0);
    wait_valid("drop_valid");
    vectors++;
    if (key !== KEY_A_H || key_mask !== MASK_A) begin
      miscompares++;
      $display("[TB] FAIL drop_key: key=%h mask=%h, expected %h %h", key, key_mask, KEY_A_H, MASK_A);
    end
    accept();
    repeat (8) @(negedge clk);
    vectors++;
    if (key_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL drop_no_second: valid=%b, expected 0", key_valid);
    end
`ifdef BIT_EXTRACT_DROPCNT_EN
    vectors++;
    if (drop_cnt !== 32'd1) begin
      miscompares++;
      $display("[TB] FAIL drop_cnt: cnt=%0d, expected 1", drop_cnt);
    end
`endif
  endtask

  task automatic test_cfg_switch();
    send_header(hdr_h);
    load_table(tbl_first);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL cfg_busy_extract: busy=%b, expected 1", busy);
    end
    wait_valid("cfg_old_valid");
    vectors++;
    if (busy !== 1'b1 || key !== KEY_A_H || key_mask !== MASK_A) begin
      miscompares++;
      $display("[TB] FAIL cfg_old: busy=%b key=%h mask=%h, expected 1 %h %h", busy, key, key_mask, KEY_A_H, MASK_A);
    end
    accept();
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL cfg_commit: busy=%b, expected 0", busy);
    end
    send_header(hdr_h);
    wait_valid("cfg_new_valid");
    vectors++;
    if (key !== BIT0 || key_mask !== BIT0) begin
      miscompares++;
      $display("[TB] FAIL cfg_new: key=%h mask=%h, expected %h %h", key, key_mask, BIT0, BIT0);
    end
    accept();
  endtask

  task automatic test_reset_in_out();
    send_header(hdr_h);
    wait_valid("rst_out_valid");
    #2;
    rst_n = 1'b0;
    key_ready = 1'b1;
    #1;
    vectors++;
    if (key_valid !== 1'b0 || key !== '0 || key_mask !== '0) begin
      miscompares++;
      $display("[TB] FAIL rst_async: valid=%b key=%h mask=%h, expected 0 0 0", key_valid, key, key_mask);
    end
    @(negedge clk);
    rst_n = 1'b1;
    key_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if (key_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rst_release: valid=%b busy=%b, expected 0 0", key_valid, busy);
    end
    send_header(hdr_h);
    wait_valid("rst_cleared_valid");
    vectors++;
    if (key !== '0 || key_mask !== '0) begin
      miscompares++;
      $display("[TB] FAIL rst_table_cleared: key=%h mask=%h, expected 0 0", key, key_mask);
    end
    accept();
    load_table(tbl_first);
    @(negedge clk);
    send_header(hdr_h);
    wait_valid("rst_fresh_valid");
    vectors++;
    if (key !== BIT0 || key_mask !== BIT0) begin
      miscompares++;
      $display("[TB] FAIL rst_fresh: key=%h mask=%h, expected %h %h", key, key_mask, BIT0, BIT0);
    end
    accept();
  endtask

  initial begin
    hdr_first = '0;
    hdr_first[1023 -: 8] = 8'h80;

    // Bytes 0, 5, 64, 127 of the network-order header.
    hdr_h = '0;
    hdr_h[1023 -: 8] = 8'h80;
    hdr_h[983 -: 8]  = 8'h10;
    hdr_h[511 -: 8]  = 8'h80;
    hdr_h[7 -: 8]    = 8'h01;

    hdr_2 = '0;
    hdr_2[511 -: 8] = 8'h80;

    tbl_first = '0;
    tbl_first[0*16 +: 16] = mk(1'b1, 0, 0);

    tbl_a = '0;
    tbl_a[1*16 +: 16]   = mk(1'b1, 128, 0);
    tbl_a[2*16 +: 16]   = mk(1'b1, 5, 3);
    tbl_a[3*16 +: 16]   = mk(1'b1, 5, 2);
    tbl_a[4*16 +: 16]   = mk(1'b0, 5, 3);
    tbl_a[64*16 +: 16]  = mk(1'b1, 64, 0);
    tbl_a[127*16 +: 16] = mk(1'b1, 127, 7);

    test_reset();
    test_passthrough();
    test_first_bit();
    test_boundary();
    test_back_to_back();
    test_drop();
    test_cfg_switch();
    test_reset_in_out();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
